execute_muldiv: RTL and testbench

//  Multi-cycle multiply/divide unit for the execute stage, run beside the single-cycle ALU.

---
 rtl/execute_muldiv.sv | 216 +++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// execute_muldiv: multi-cycle multiply/divide unit that sits beside the single-cycle ALU.
//   It computes MUL (low half), MULH (high half), DIV (quotient) and REM (remainder),
//   on either unsigned or two's-complement operands. Each operation takes WIDTH iterations.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 decoded mul/div instruction present in EX
//   i_nop, i_halt_sig       EX holds a bubble / halt; start is ignored
//   i_flush                 kill any in-flight operation
//   i_op                    00 MUL, 01 MULH, 10 DIV, 11 REM
//   i_sign                  1 = two's-complement operands
//   i_rs_data, i_rt_data    register-file operands
//   i_exdm_rd_data          EX/DM forwarding value
//   i_dmwb_rd_data          DM/WB forwarding value
//   i_a_sel, i_b_sel        01 = EX/DM, 10 = DM/WB, otherwise the register operand
//   o_stall                 hold IF/ID/EX while an operation is pending
//   o_result_valid          one-cycle pulse when o_result is fresh
//   o_result                selected result, held until the next completed operation
//   o_div_zero              the current result came from a divide-by-zero
module execute_muldiv #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_nop,
  input  logic             i_halt_sig,
  input  logic             i_flush,
  input  logic [1:0]       i_op,
  input  logic             i_sign,
  input  logic [WIDTH-1:0] i_rs_data,
  input  logic [WIDTH-1:0] i_rt_data,
  input  logic [WIDTH-1:0] i_exdm_rd_data,
  input  logic [WIDTH-1:0] i_dmwb_rd_data,
  input  logic [1:0]       i_a_sel,
  input  logic [1:0]       i_b_sel,
  output logic             o_stall,
  output logic             o_result_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] OpMul  = 2'b00;
  localparam logic [1:0] OpMulh = 2'b01;
  localparam logic [1:0] OpDiv  = 2'b10;
  localparam logic [1:0] OpRem  = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e r_state;
  state_e w_state_nxt;

  // Operation context captured at accept
  logic [1:0]       r_op;
  logic             r_neg_q;   // negate product / quotient
  logic             r_neg_r;   // negate remainder (dividend sign)
  logic             r_dz;      // divisor was zero
  logic [WIDTH-1:0] r_a_raw;   // unmodified A, returned by REM on divide-by-zero
  logic [WIDTH-1:0] r_b;       // |B|
  logic [CW-1:0]    r_cnt;

  // Shared iteration registers: multiply {hi,lo} = partial product / multiplier,
  // divide hi = partial remainder, lo = dividend shifting out / quotient shifting in.
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] r_result;
  logic             r_div_zero;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_final;

  // Operand forwarding muxes
  always_comb begin
    unique case (i_a_sel)
      2'b01:   w_a = i_exdm_rd_data;
      2'b10:   w_a = i_dmwb_rd_data;
      default: w_a = i_rs_data;
    endcase
    unique case (i_b_sel)
      2'b01:   w_b = i_exdm_rd_data;
      2'b10:   w_b = i_dmwb_rd_data;
      default: w_b = i_rt_data;
    endcase
  end

  assign w_a_neg = i_sign & w_a[WIDTH-1];
  assign w_b_neg = i_sign & w_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -w_a : w_a;
  assign w_b_mag = w_b_neg ? -w_b : w_b;

  assign w_accept = i_start & ~i_nop & ~i_halt_sig & ~i_flush &
                    ((r_state == StIdle) | (r_state == StDone));
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // One iteration of shift-add multiply or restoring divide
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_qbit      = ~w_div_diff[WIDTH];

  always_comb begin
    if (r_op[1]) begin
      w_hi_nxt = w_qbit ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_qbit};
    end else begin
      w_hi_nxt = w_mul_sum[WIDTH:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up on the last iteration's values. Signed MIN / -1 falls out naturally:
  // |MIN| / 1 = MIN, and negating MIN wraps back to MIN with remainder 0.
  assign w_prod   = {w_hi_nxt, w_lo_nxt};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quot   = r_neg_q ? -w_lo_nxt : w_lo_nxt;
  assign w_rem    = r_neg_r ? -w_hi_nxt : w_hi_nxt;

  always_comb begin
    unique case (r_op)
      OpMul:   w_final = w_prod_s[WIDTH-1:0];
      OpMulh:  w_final = w_prod_s[2*WIDTH-1:WIDTH];
      OpDiv:   w_final = r_dz ? '1 : w_quot;
      OpRem:   w_final = r_dz ? r_a_raw : w_rem;
      default: w_final = '0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (w_accept) w_state_nxt = StRun;
        StRun:   if (w_last) w_state_nxt = StDone;
        StDone:  w_state_nxt = w_accept ? StRun : StIdle;
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    o_stall        = w_accept | (r_state == StRun);
    o_result_valid = (r_state == StDone);
  end

  // Datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op       <= OpMul;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_a_raw    <= '0;
      r_b        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_op    <= i_op;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dz    <= (w_b == '0);
      r_a_raw <= w_a;
      r_b     <= w_b_mag;
      r_hi    <= '0;
      r_lo    <= w_a_mag;
      r_cnt   <= '0;
    end else if ((r_state == StRun) && !i_flush) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_result   <= w_final;
        r_div_zero <= r_dz & r_op[1];
      end
    end
  end

  assign o_result   = r_result;
  assign o_div_zero = r_div_zero;

endmodule

// File: tb/tb_execute_muldiv.sv
module tb_execute_muldiv;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst, start, nop, halt_sig, flush, sgn;
  logic [1:0]   op, a_sel, b_sel;
  logic [W-1:0] rs_data, rt_data, exdm_data, dmwb_data;
  logic         stall, result_valid, div_zero;
  logic [W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  execute_muldiv #(.WIDTH(W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_nop          (nop),
    .i_halt_sig     (halt_sig),
    .i_flush        (flush),
    .i_op           (op),
    .i_sign         (sgn),
    .i_rs_data      (rs_data),
    .i_rt_data      (rt_data),
    .i_exdm_rd_data (exdm_data),
    .i_dmwb_rd_data (dmwb_data),
    .i_a_sel        (a_sel),
    .i_b_sel        (b_sel),
    .o_stall        (stall),
    .o_result_valid (result_valid),
    .o_result       (result),
    .o_div_zero     (div_zero)
  );

  typedef struct {
    string      name;
    logic [1:0] op;
    logic       sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic       dz;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation from the negedge; report cycles from accept to the valid pulse and
  // the number of stall cycles seen. Forwarding inputs are scrambled after accept.
  task automatic do_op(input logic [1:0] o, input logic s, input logic [15:0] rs,
                       input logic [15:0] rt, input logic [15:0] exdm, input logic [15:0] dmwb,
                       input logic [1:0] asel, input logic [1:0] bsel,
                       output int lat, output int stalls);
    @(negedge clk);
    start = 1'b1; op = o; sgn = s; rs_data = rs; rt_data = rt;
    exdm_data = exdm; dmwb_data = dmwb; a_sel = asel; b_sel = bsel;
    #1 stalls = stall ? 1 : 0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        rs_data = 16'h0100; rt_data = 16'h0100; exdm_data = 16'h0100; dmwb_data = 16'h0100;
      end
      #1;
      if (result_valid) begin
        lat = c;
        break;
      end
      if (stall) stalls++;
    end
  endtask

  int lat, stalls, pulses, p1, p2;

  initial begin
    rst = 1'b1; start = 1'b0; nop = 1'b0; halt_sig = 1'b0; flush = 1'b0; sgn = 1'b0;
    op = 2'b00; a_sel = 2'b00; b_sel = 2'b00;
    rs_data = '0; rt_data = '0; exdm_data = '0; dmwb_data = '0;

    vecs.push_back('{"mul_u_3x5",        2'b00, 1'b0, 16'h0003, 16'h0005, 16'h000F, 1'b0});
    vecs.push_back('{"mulh_s_m1x2",      2'b01, 1'b1, 16'hFFFF, 16'h0002, 16'hFFFF, 1'b0});
    vecs.push_back('{"mul_s_m1x2",       2'b00, 1'b1, 16'hFFFF, 16'h0002, 16'hFFFE, 1'b0});
    vecs.push_back('{"div_s_m7d2",       2'b10, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0});
    vecs.push_back('{"rem_s_m7d2",       2'b11, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0});
    vecs.push_back('{"div_s_min_m1",     2'b10, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b0});
    vecs.push_back('{"rem_s_min_m1",     2'b11, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 1'b0});
    vecs.push_back('{"div_u_by0",        2'b10, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 1'b1});
    vecs.push_back('{"rem_u_by0",        2'b11, 1'b0, 16'h1234, 16'h0000, 16'h1234, 1'b1});
    vecs.push_back('{"div_s_by0",        2'b10, 1'b1, 16'hFFF0, 16'h0000, 16'hFFFF, 1'b1});
    vecs.push_back('{"rem_s_by0",        2'b11, 1'b1, 16'hFFF0, 16'h0000, 16'hFFF0, 1'b1});
    vecs.push_back('{"mulh_u_max",       2'b01, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0});
    vecs.push_back('{"mul_u_max",        2'b00, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0});
    vecs.push_back('{"div_u_100d7",      2'b10, 1'b0, 16'h0064, 16'h0007, 16'h000E, 1'b0});
    vecs.push_back('{"rem_u_100d7",      2'b11, 1'b0, 16'h0064, 16'h0007, 16'h0002, 1'b0});
    vecs.push_back('{"div_s_7dm2",       2'b10, 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 1'b0});
    vecs.push_back('{"rem_s_7dm2",       2'b11, 1'b1, 16'h0007, 16'hFFFE, 16'h0001, 1'b0});
    vecs.push_back('{"mulh_s_minxmin",   2'b01, 1'b1, 16'h8000, 16'h8000, 16'h4000, 1'b0});
    vecs.push_back('{"mul_s_minxmin",    2'b00, 1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b0});

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_valid", {31'd0, result_valid}, 32'd0);
    check("reset_result", {16'd0, result}, 32'd0);
    check("reset_div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven arithmetic
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, 16'h5555, 16'hAAAA, 2'b00, 2'b00,
            lat, stalls);
      check({vecs[i].name, "_latency"}, lat, 17);
      check({vecs[i].name, "_stalls"}, stalls, 17);
      check({vecs[i].name, "_result"}, {16'd0, result}, {16'd0, vecs[i].res});
      check({vecs[i].name, "_div_zero"}, {31'd0, div_zero}, {31'd0, vecs[i].dz});
      @(negedge clk);
      #1 check({vecs[i].name, "_pulse_width"}, {31'd0, result_valid}, 32'd0);
    end

    // Forwarding: A from EX/DM, later change must not leak in
    do_op(2'b00, 1'b0, 16'h1111, 16'h0003, 16'h0007, 16'h2222, 2'b01, 2'b00, lat, stalls);
    check("fwd_exdm_latency", lat, 17);
    check("fwd_exdm_result", {16'd0, result}, 32'h0015);
    // B from DM/WB
    do_op(2'b00, 1'b0, 16'h0002, 16'h1111, 16'h2222, 16'h0009, 2'b00, 2'b10, lat, stalls);
    check("fwd_dmwb_result", {16'd0, result}, 32'h0012);

    // NOP / HaltSig suppress start
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1; nop = (k == 0); halt_sig = (k == 1);
      #1 check(k == 0 ? "nop_stall" : "halt_stall", {31'd0, stall}, 32'd0);
      pulses = 0;
      repeat (20) begin
        @(negedge clk);
        #1 if (result_valid) pulses++;
      end
      check(k == 0 ? "nop_no_valid" : "halt_no_valid", pulses, 0);
      start = 1'b0; nop = 1'b0; halt_sig = 1'b0;
    end

    // flush together with start: flush wins
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    #1 check("flush_start_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1 check("flush_start_idle_stall", {31'd0, stall}, 32'd0);

    // Establish a divide-by-zero result, then flush on RUN cycle 5
    do_op(2'b10, 1'b0, 16'h1234, 16'h0000, 16'h0, 16'h0, 2'b00, 2'b00, lat, stalls);
    check("pre_flush_result", {16'd0, result}, 32'hFFFF);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1; op = 2'b00; sgn = 1'b0; rs_data = 16'h0003; rt_data = 16'h0005;
      a_sel = 2'b00; b_sel = 2'b00;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      if (k == 0) flush = 1'b1; else rst = 1'b1;
      @(negedge clk);
      flush = 1'b0; rst = 1'b0;
      #1 check(k == 0 ? "flush_stall_drop" : "rst_stall_drop", {31'd0, stall}, 32'd0);
      pulses = 0;
      repeat (25) begin
        @(negedge clk);
        #1 if (result_valid) pulses++;
      end
      if (k == 0) begin
        check("flush_no_valid", pulses, 0);
        check("flush_result_kept", {16'd0, result}, 32'hFFFF);
        check("flush_div_zero_kept", {31'd0, div_zero}, 32'd1);
      end else begin
        check("rst_no_valid", pulses, 0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_div_zero", {31'd0, div_zero}, 32'd0);
      end
    end

    // Back-to-back MULs with start held through DONE
    @(negedge clk);
    start = 1'b1; op = 2'b00; sgn = 1'b0; rs_data = 16'h0003; rt_data = 16'h0005;
    p1 = -1; p2 = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      #1;
      if (result_valid) begin
        if (p1 < 0) begin
          p1 = c;
          check("b2b_first_result", {16'd0, result}, 32'h000F);
          check("b2b_done_stall", {31'd0, stall}, 32'd1);
          rs_data = 16'h0004;
        end else begin
          p2 = c;
          check("b2b_second_result", {16'd0, result}, 32'h0014);
          start = 1'b0;
          break;
        end
      end
    end
    check("b2b_first_pulse", p1, 17);
    check("b2b_second_pulse", p2, 34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
